// File: rtl/uart_byte_rx.sv
// UART byte receiver (8N1, LSB first) with its own 16x oversampling tick and a 7-sample majority vote per bit.
// Latency: start edge to Rx_Done is about (9*16+13)*(DIV+1)+3 Clk; the sync/edge-detect path adds 3 Clk.
// Backpressure: none. Rx_Done and Frame_Err are single-Clk strobes, and Data_Byte holds until the next good frame.
module uart_byte_rx #(
    parameter int unsigned SYS_CLK = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] Baud_Set,
    input  logic       Rs232_Rx,
    output logic [7:0] Data_Byte,
    output logic       Rx_Done,
    output logic       Frame_Err,
    output logic       Rx_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic [8:0] div_of(input int unsigned baud);
        return 9'(SYS_CLK / (baud * 32'd16) - 32'd1);
    endfunction

    function automatic logic [8:0] div_for(input logic [2:0] sel);
        logic [8:0] d;
        case (sel)
            3'd0:    d = div_of(32'd9600);
            3'd1:    d = div_of(32'd19200);
            3'd2:    d = div_of(32'd38400);
            3'd3:    d = div_of(32'd57600);
            3'd4:    d = div_of(32'd115200);
            3'd5:    d = div_of(32'd230400);
            3'd6:    d = div_of(32'd460800);
            default: d = div_of(32'd921600);
        endcase
        return d;
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       fall;
    logic [8:0] div_lat;
    logic [8:0] tick_cnt;
    logic       tick;
    logic [3:0] sub_cnt;
    logic [3:0] bit_idx;
    logic [2:0] acc;
    logic [3:0] vote_sum;
    logic       voted;
    logic       in_window;
    logic       decide;
    logic       bit_end;
    logic [7:0] shreg;
    logic       busy_nxt;
    logic       done_nxt;
    logic       ferr_nxt;
    logic       load_byte;
    logic       start_frame;

    // Sync flops come out of reset at the idle-line level so release never looks like a start edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= Rs232_Rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall      = !sync2 && sync3;
    assign tick      = Rx_Busy && (tick_cnt == div_lat);
    assign in_window = (sub_cnt >= 4'd6) && (sub_cnt <= 4'd12);
    assign decide    = tick && (sub_cnt == 4'd12);
    assign bit_end   = tick && (sub_cnt == 4'd15);
    // The seventh sample is folded in combinationally so the decision lands on the sub-tick-12 tick itself.
    assign vote_sum  = {1'b0, acc} + {3'b000, sync2};
    assign voted     = (vote_sum >= 4'd4);

    always_comb begin
        state_nxt   = state;
        busy_nxt    = Rx_Busy;
        done_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        load_byte   = 1'b0;
        start_frame = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    start_frame = 1'b1;
                    busy_nxt    = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                if (decide && voted) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 4'd8)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving mid stop bit leaves room to catch a back-to-back start edge.
                if (decide) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                    if (voted) begin
                        done_nxt  = 1'b1;
                        load_byte = 1'b1;
                    end else begin
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            Rx_Busy   <= 1'b0;
            Rx_Done   <= 1'b0;
            Frame_Err <= 1'b0;
            Data_Byte <= 8'h00;
            div_lat   <= 9'd0;
        end else begin
            state     <= state_nxt;
            Rx_Busy   <= busy_nxt;
            Rx_Done   <= done_nxt;
            Frame_Err <= ferr_nxt;
            if (load_byte) begin
                Data_Byte <= shreg;
            end
            if (start_frame) begin
                div_lat <= div_for(Baud_Set);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tick_cnt <= 9'd0;
            sub_cnt  <= 4'd0;
            bit_idx  <= 4'd0;
            acc      <= 3'd0;
            shreg    <= 8'h00;
        end else if (state == IDLE) begin
            tick_cnt <= 9'd0;
            sub_cnt  <= 4'd0;
            bit_idx  <= 4'd0;
            acc      <= 3'd0;
        end else begin
            tick_cnt <= tick ? 9'd0 : tick_cnt + 9'd1;
            if (tick) begin
                sub_cnt <= sub_cnt + 4'd1;
                if (in_window) begin
                    acc <= acc + {2'b00, sync2};
                end else if (sub_cnt == 4'd13) begin
                    acc <= 3'd0;
                end
            end
            if (bit_end) begin
                bit_idx <= bit_idx + 4'd1;
            end
            if ((state == DATA) && decide) begin
                shreg <= {voted, shreg[7:1]};
            end
        end
    end

endmodule
